// File: rtl/uart_ctrl.sv
// UART register front-end: CPU-bus register slot that configures the uart_rx/uart_tx
// blocks and owns the baud divisor, sticky error/timeout flags and the interrupt line.
module uart_ctrl #(
   parameter logic [15:0] DEFAULT_DIV = 16'd26,
   parameter logic [7:0]  DEFAULT_TO  = 8'd0
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_cs,
   input  logic        i_we,
   input  logic [2:0]  i_addr,
   input  logic [7:0]  i_wdata,
   output logic [7:0]  o_rdata,
   output logic        o_irq,
   output logic        o_rx_enable,
   output logic        o_tx_enable,
   output logic [15:0] o_baud_div,
   output logic        o_rx_read,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_ready,
   input  logic        i_rx_full,
   input  logic        i_rx_error,
   input  logic        i_rx_line,
   output logic        o_tx_write,
   output logic [7:0]  o_tx_data,
   input  logic        i_tx_full,
   input  logic        i_tx_idle
);

   localparam logic [2:0] A_DATA    = 3'd0;
   localparam logic [2:0] A_STATUS  = 3'd1;
   localparam logic [2:0] A_CTRL    = 3'd2;
   localparam logic [2:0] A_DIV_LO  = 3'd3;
   localparam logic [2:0] A_DIV_HI  = 3'd4;
   localparam logic [2:0] A_TIMEOUT = 3'd5;

   logic [5:0]  r_ctrl;
   logic [7:0]  r_div_lo;
   logic [15:0] r_baud_div;
   logic [7:0]  r_timeout;
   logic        r_ferr;
   logic        r_rxto;
   logic        r_irq;
   logic        r_tx_write;
   logic [7:0]  r_tx_data;
   logic        r_err_d;
   logic        r_line_s1;
   logic        r_line_s2;
   logic        r_line_s3;
   logic [19:0] r_presc;
   logic [7:0]  r_idle;
   logic        r_to_armed;

   logic        w_wr;
   logic        w_pop;
   logic        w_div_load;
   logic        w_status_wr;
   logic        w_tick;
   logic        w_err_rise;
   logic        w_line_fall;
   logic        w_idle_clr;
   logic        w_to_hit;
   logic [7:0]  w_status;

   assign w_wr        = i_cs & i_we;
   assign w_pop       = i_cs & ~i_we & (i_addr == A_DATA) & i_rx_ready;
   assign w_div_load  = w_wr & (i_addr == A_DIV_HI);
   assign w_status_wr = w_wr & (i_addr == A_STATUS);
   assign w_tick      = (r_presc == 20'd0);
   assign w_err_rise  = i_rx_error & ~r_err_d;
   assign w_line_fall = r_line_s3 & ~r_line_s2;
   assign w_idle_clr  = ~r_ctrl[0] | ~i_rx_ready | w_pop | w_line_fall;
   // One timeout event per idle run: the armed flag drops on the hit and only
   // comes back once the idle counter has been cleared.
   assign w_to_hit    = r_to_armed & (r_timeout != 8'd0) & (r_idle == r_timeout) & ~w_idle_clr;

   assign w_status = {r_irq, 1'b0, r_rxto, r_ferr, i_tx_idle, ~i_tx_full, i_rx_full, i_rx_ready};

   assign o_rx_read   = w_pop;
   assign o_rx_enable = r_ctrl[0];
   assign o_tx_enable = r_ctrl[1];
   assign o_baud_div  = r_baud_div;
   assign o_irq       = r_irq;
   assign o_tx_write  = r_tx_write;
   assign o_tx_data   = r_tx_data;

   always_comb begin
      o_rdata = 8'h00;
      case (i_addr)
         A_DATA:    o_rdata = i_rx_data;
         A_STATUS:  o_rdata = w_status;
         A_CTRL:    o_rdata = {2'b00, r_ctrl};
         A_DIV_LO:  o_rdata = r_div_lo;
         A_DIV_HI:  o_rdata = r_baud_div[15:8];
         A_TIMEOUT: o_rdata = r_timeout;
         default:   o_rdata = 8'h00;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_ctrl     <= 6'd0;
         r_div_lo   <= 8'd0;
         r_baud_div <= DEFAULT_DIV;
         r_timeout  <= DEFAULT_TO;
         r_tx_write <= 1'b0;
         r_tx_data  <= 8'd0;
      end else begin
         r_tx_write <= w_wr & (i_addr == A_DATA) & ~i_tx_full;
         if (w_wr & (i_addr == A_DATA) & ~i_tx_full) r_tx_data <= i_wdata;
         if (w_wr & (i_addr == A_CTRL))    r_ctrl     <= i_wdata[5:0];
         if (w_wr & (i_addr == A_DIV_LO))  r_div_lo   <= i_wdata;
         if (w_div_load)                   r_baud_div <= {i_wdata, r_div_lo};
         if (w_wr & (i_addr == A_TIMEOUT)) r_timeout  <= i_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_err_d   <= 1'b0;
         r_line_s1 <= 1'b1;
         r_line_s2 <= 1'b1;
         r_line_s3 <= 1'b1;
         r_ferr    <= 1'b0;
         r_rxto    <= 1'b0;
         r_irq     <= 1'b0;
      end else begin
         r_err_d   <= i_rx_error;
         r_line_s1 <= i_rx_line;
         r_line_s2 <= r_line_s1;
         r_line_s3 <= r_line_s2;
         if (w_err_rise)                         r_ferr <= 1'b1;
         else if (w_status_wr & i_wdata[4])      r_ferr <= 1'b0;
         if (w_to_hit)                           r_rxto <= 1'b1;
         else if (w_status_wr & i_wdata[5])      r_rxto <= 1'b0;
         r_irq <= (r_ctrl[2] & i_rx_ready) | (r_ctrl[3] & ~i_tx_full) |
                  (r_ctrl[4] & r_ferr)     | (r_ctrl[5] & r_rxto);
      end
   end

   // Bit-time prescaler: down-counter reloaded with 16*(div+1)-1, tick at zero.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_presc    <= 20'd0;
         r_idle     <= 8'd0;
         r_to_armed <= 1'b1;
      end else begin
         if (w_div_load)  r_presc <= {i_wdata, r_div_lo, 4'hF};
         else if (w_tick) r_presc <= {r_baud_div, 4'hF};
         else             r_presc <= r_presc - 20'd1;
         if (w_idle_clr)                        r_idle <= 8'd0;
         else if (w_tick && r_idle != 8'hFF)    r_idle <= r_idle + 8'd1;
         if (w_idle_clr)    r_to_armed <= 1'b1;
         else if (w_to_hit) r_to_armed <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_ctrl.sv
// Bench for uart_ctrl: directed scenarios plus randomized register, RX and TX traffic
// checked against a register-map / FIFO model kept in the bench.
module tb_uart_ctrl;
   logic        clk = 1'b0;
   logic        i_reset_n;
   logic        i_cs, i_we;
   logic [2:0]  i_addr;
   logic [7:0]  i_wdata;
   logic [7:0]  o_rdata;
   logic        o_irq, o_rx_enable, o_tx_enable, o_rx_read, o_tx_write;
   logic [15:0] o_baud_div;
   logic [7:0]  i_rx_data;
   logic        i_rx_ready, i_rx_full, i_rx_error, i_rx_line;
   logic [7:0]  o_tx_data;
   logic        i_tx_full, i_tx_idle;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] rxq[$];
   logic [7:0] m_ctrl, m_lo, m_to;
   logic [15:0] m_div;

   uart_ctrl dut (
      .i_clk(clk), .i_reset_n(i_reset_n), .i_cs(i_cs), .i_we(i_we), .i_addr(i_addr),
      .i_wdata(i_wdata), .o_rdata(o_rdata), .o_irq(o_irq), .o_rx_enable(o_rx_enable),
      .o_tx_enable(o_tx_enable), .o_baud_div(o_baud_div), .o_rx_read(o_rx_read),
      .i_rx_data(i_rx_data), .i_rx_ready(i_rx_ready), .i_rx_full(i_rx_full),
      .i_rx_error(i_rx_error), .i_rx_line(i_rx_line), .o_tx_write(o_tx_write),
      .o_tx_data(o_tx_data), .i_tx_full(i_tx_full), .i_tx_idle(i_tx_idle)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic rx_drive();
      i_rx_ready = (rxq.size() != 0);
      i_rx_data  = (rxq.size() != 0) ? rxq[0] : 8'hEE;
      i_rx_full  = (rxq.size() >= 4);
   endtask

   task automatic do_write(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      i_cs = 1'b1; i_we = 1'b1; i_addr = a; i_wdata = d;
      @(negedge clk);
      i_cs = 1'b0; i_we = 1'b0;
   endtask

   task automatic do_read(input logic [2:0] a, output logic [7:0] d, output logic p);
      @(negedge clk);
      i_cs = 1'b1; i_we = 1'b0; i_addr = a;
      #1;
      d = o_rdata;
      p = o_rx_read;
      @(negedge clk);
      i_cs = 1'b0;
   endtask

   task automatic rx_read_check(input string tag);
      logic [7:0] d, exp_d;
      logic p, exp_p;
      exp_p = (rxq.size() != 0);
      exp_d = exp_p ? rxq[0] : 8'hEE;
      do_read(3'd0, d, p);
      check({tag, "_data"}, d, exp_d);
      check({tag, "_pop"}, p, exp_p);
      if (exp_p) begin
         void'(rxq.pop_front());
         rx_drive();
      end
   endtask

   function automatic logic [7:0] model_reg(input logic [2:0] a);
      case (a)
         3'd2:    return m_ctrl;
         3'd3:    return m_lo;
         3'd4:    return m_div[15:8];
         3'd5:    return m_to;
         default: return 8'h00;
      endcase
   endfunction

   task automatic wait_irq(input int budget, output int k);
      k = 0;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (o_irq) begin
            k = i;
            break;
         end
      end
   endtask

   initial begin
      logic [7:0] d, w;
      logic p, full;
      logic [7:0] exp_txd;
      int k;

      i_reset_n = 1'b0; i_cs = 1'b0; i_we = 1'b0; i_addr = 3'd0; i_wdata = 8'd0;
      i_rx_error = 1'b0; i_rx_line = 1'b1; i_tx_full = 1'b1; i_tx_idle = 1'b1;
      rx_drive();
      repeat (3) @(negedge clk);
      i_reset_n = 1'b1;
      @(negedge clk);

      check("rst_div", o_baud_div, 16'd26);
      check("rst_irq", o_irq, 1'b0);
      check("rst_txw", o_tx_write, 1'b0);
      check("rst_en", {o_rx_enable, o_tx_enable}, 2'b00);
      do_read(3'd2, d, p);
      check("rst_ctrl", d, 8'h00);
      do_read(3'd1, d, p);
      check("rst_status_full", d, 8'h08);
      i_tx_full = 1'b0;
      do_read(3'd1, d, p);
      check("rst_status", d, 8'h0C);

      // divisor: low byte is shadow only, high byte commits both
      do_write(3'd3, 8'h34);
      check("div_after_lo", o_baud_div, 16'd26);
      do_read(3'd3, d, p);
      check("div_lo_rd", d, 8'h34);
      do_write(3'd4, 8'h12);
      check("div_after_hi", o_baud_div, 16'h1234);
      do_read(3'd4, d, p);
      check("div_hi_rd", d, 8'h12);

      // RX pops
      rxq.push_back(8'hA5); rxq.push_back(8'h5A); rx_drive();
      rx_read_check("rx1");
      rx_read_check("rx2");
      rx_read_check("rx3_empty");
      for (int r = 0; r < 6; r++) begin
         for (int j = 0; j < int'($urandom_range(0, 3)); j++) rxq.push_back(8'($urandom));
         rx_drive();
         for (int j = 0; j < int'($urandom_range(1, 3)); j++) rx_read_check("rx_rand");
      end
      rxq.delete(); rx_drive();

      // framing error
      do_write(3'd2, 8'h10);
      @(negedge clk); i_rx_error = 1'b1;
      @(negedge clk); i_rx_error = 1'b0;
      @(negedge clk);
      check("ferr_irq", o_irq, 1'b1);
      do_read(3'd1, d, p);
      check("ferr_status", d & 8'h90, 8'h90);
      do_write(3'd1, 8'h10);
      check("ferr_irq_lag", o_irq, 1'b1);
      @(negedge clk);
      check("ferr_irq_drop", o_irq, 1'b0);
      do_read(3'd1, d, p);
      check("ferr_cleared", d[4], 1'b0);
      @(negedge clk);
      i_rx_error = 1'b1; i_cs = 1'b1; i_we = 1'b1; i_addr = 3'd1; i_wdata = 8'h10;
      @(negedge clk);
      i_cs = 1'b0; i_we = 1'b0; i_rx_error = 1'b0;
      do_read(3'd1, d, p);
      check("ferr_set_wins", d[4], 1'b1);
      do_write(3'd1, 8'h10);

      // RX timeout: div=0 -> 16 clk bit-time, TIMEOUT=3
      do_write(3'd2, 8'h21);
      do_write(3'd5, 8'h03);
      do_write(3'd3, 8'h00);
      @(negedge clk);
      rxq.push_back(8'hC3); rx_drive();
      i_cs = 1'b1; i_we = 1'b1; i_addr = 3'd4; i_wdata = 8'h00;
      @(negedge clk);
      i_cs = 1'b0; i_we = 1'b0;
      wait_irq(100, k);
      check("rxto_irq_cycle", k, 50);
      do_read(3'd1, d, p);
      check("rxto_status", d[5], 1'b1);
      do_write(3'd1, 8'h20);
      repeat (80) @(negedge clk);
      do_read(3'd1, d, p);
      check("rxto_no_rearm", d[5], 1'b0);
      check("rxto_no_rearm_irq", o_irq, 1'b0);
      rx_read_check("rxto_pop");
      rxq.push_back(8'h3C); rx_drive();
      wait_irq(100, k);
      check("rxto_rearm", k != 0, 1'b1);
      do_write(3'd1, 8'h20);
      rx_read_check("rxto_pop2");
      rxq.push_back(8'h99); rx_drive();
      repeat (40) @(negedge clk);
      i_rx_line = 1'b0;
      repeat (2) @(negedge clk);
      i_rx_line = 1'b1;
      repeat (28) @(negedge clk);
      check("rxto_line_clr", o_irq, 1'b0);
      wait_irq(80, k);
      check("rxto_after_line", k != 0, 1'b1);
      do_write(3'd1, 8'h20);
      rx_read_check("rxto_pop3");
      do_write(3'd2, 8'h00);

      // TX pushes
      i_tx_full = 1'b1;
      do_write(3'd0, 8'h41);
      check("tx_full_drop", o_tx_write, 1'b0);
      i_tx_full = 1'b0;
      do_write(3'd0, 8'h42);
      check("tx_pulse", o_tx_write, 1'b1);
      check("tx_data", o_tx_data, 8'h42);
      @(negedge clk);
      check("tx_pulse_end", o_tx_write, 1'b0);
      exp_txd = 8'h42;
      for (int r = 0; r < 12; r++) begin
         full = 1'($urandom_range(0, 1));
         w = 8'($urandom);
         i_tx_full = full;
         do_write(3'd0, w);
         if (!full) exp_txd = w;
         check("tx_rand_pulse", o_tx_write, !full);
         check("tx_rand_data", o_tx_data, exp_txd);
      end
      i_tx_full = 1'b0;

      // random register traffic
      m_ctrl = 8'h00; m_lo = 8'h00; m_div = 16'h0000; m_to = 8'h03;
      for (int r = 0; r < 30; r++) begin
         logic [2:0] a;
         a = 3'($urandom_range(2, 7));
         w = 8'($urandom);
         do_write(a, w);
         case (a)
            3'd2: m_ctrl = w & 8'h3F;
            3'd3: m_lo = w;
            3'd4: m_div = {w, m_lo};
            3'd5: m_to = w;
            default: ;
         endcase
         do_read(a, d, p);
         check("reg_rd", d, model_reg(a));
         check("reg_div", o_baud_div, m_div);
         check("reg_en", {o_tx_enable, o_rx_enable}, m_ctrl[1:0]);
      end
      do_write(3'd2, 8'h00);

      // async reset in the middle of a TX write access
      do_write(3'd4, 8'h55);
      @(negedge clk);
      i_cs = 1'b1; i_we = 1'b1; i_addr = 3'd0; i_wdata = 8'h77;
      #2 i_reset_n = 1'b0;
      @(negedge clk);
      i_cs = 1'b0; i_we = 1'b0;
      check("rst_mid_txw", o_tx_write, 1'b0);
      @(negedge clk);
      i_reset_n = 1'b1;
      @(negedge clk);
      check("rst_mid_txw2", o_tx_write, 1'b0);
      check("rst_mid_txd", o_tx_data, 8'h00);
      check("rst_mid_div", o_baud_div, 16'd26);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
